// File: rtl/em_pipe_reg_if.sv
// Bundle of EX->MEM pipeline register signals: E-stage inputs, M-stage outputs,
// and the hazard-unit forwarding port. The pipeline register itself uses the slave modport.
interface em_pipe_reg_if #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int TW = 2,
    parameter int CW = 16
);
    logic          stall;
    logic          flush;

    logic [DW-1:0] e_pc;
    logic [DW-1:0] e_instr;
    logic [DW-1:0] e_alu;
    logic [DW-1:0] e_md;
    logic [DW-1:0] e_rd2;
    logic [RW-1:0] e_a2;
    logic [RW-1:0] e_a3;
    logic          e_we;
    logic [1:0]    e_wdsel;
    logic [TW-1:0] e_tnew;

    logic [DW-1:0] m_pc;
    logic [DW-1:0] m_instr;
    logic [DW-1:0] m_alu;
    logic [DW-1:0] m_md;
    logic [DW-1:0] m_rd2;
    logic [RW-1:0] m_a2;
    logic [RW-1:0] m_a3;
    logic          m_we;
    logic [1:0]    m_wdsel;
    logic [TW-1:0] m_tnew;
    logic          m_valid;

    logic [DW-1:0] fwd_val;
    logic [RW-1:0] fwd_a3;
    logic          fwd_we;
    logic          fwd_ready;
    logic [CW-1:0] bubble_cnt;

    modport master (
        output stall, flush,
        output e_pc, e_instr, e_alu, e_md, e_rd2, e_a2, e_a3, e_we, e_wdsel, e_tnew,
        input  m_pc, m_instr, m_alu, m_md, m_rd2, m_a2, m_a3, m_we, m_wdsel, m_tnew, m_valid,
        input  fwd_val, fwd_a3, fwd_we, fwd_ready, bubble_cnt
    );

    modport slave (
        input  stall, flush,
        input  e_pc, e_instr, e_alu, e_md, e_rd2, e_a2, e_a3, e_we, e_wdsel, e_tnew,
        output m_pc, m_instr, m_alu, m_md, m_rd2, m_a2, m_a3, m_we, m_wdsel, m_tnew, m_valid,
        output fwd_val, fwd_a3, fwd_we, fwd_ready, bubble_cnt
    );
endinterface

// File: rtl/em_pipe_reg.sv
// EX->MEM pipeline register with stall/flush, valid tracking, Tnew countdown,
// a saturating bubble counter and a registered-side forwarding port for the hazard unit.
module em_pipe_reg #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int TW      = 2,
    parameter int CW      = 16,
    parameter int KEEP_PC = 1
) (
    input logic          clk,
    input logic          reset,
    em_pipe_reg_if.slave bus
);

    localparam logic [1:0]    WDSEL_DM   = 2'b00;
    localparam logic [1:0]    WDSEL_ALU  = 2'b01;
    localparam logic [1:0]    WDSEL_PC8  = 2'b10;
    localparam logic [1:0]    WDSEL_MD   = 2'b11;
    localparam logic [CW-1:0] BUBBLE_MAX = '1;

    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_md;
    logic [DW-1:0] r_rd2;
    logic [RW-1:0] r_a2;
    logic [RW-1:0] r_a3;
    logic          r_we;
    logic [1:0]    r_wdsel;
    logic [TW-1:0] r_tnew;
    logic          r_valid;
    logic [CW-1:0] r_bubbleCnt;

    logic [DW-1:0] w_fwdVal;
    logic          w_fwdWe;
    logic          w_fwdReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_instr     <= '0;
            r_alu       <= '0;
            r_md        <= '0;
            r_rd2       <= '0;
            r_a2        <= '0;
            r_a3        <= '0;
            r_we        <= 1'b0;
            r_wdsel     <= '0;
            r_tnew      <= '0;
            r_valid     <= 1'b0;
            r_bubbleCnt <= '0;
        end else begin
            // Counts edges that leave a bubble behind, judged on the state before the edge.
            if (!r_valid && (r_bubbleCnt != BUBBLE_MAX)) begin
                r_bubbleCnt <= r_bubbleCnt + 1'b1;
            end

            if (bus.flush) begin
                r_pc    <= (KEEP_PC != 0) ? bus.e_pc : '0;
                r_instr <= '0;
                r_alu   <= '0;
                r_md    <= '0;
                r_rd2   <= '0;
                r_a2    <= '0;
                r_a3    <= '0;
                r_we    <= 1'b0;
                r_wdsel <= '0;
                r_tnew  <= '0;
                r_valid <= 1'b0;
            end else if (bus.stall) begin
                // Held instruction keeps maturing toward a forwardable result.
                if (r_tnew != '0) begin
                    r_tnew <= r_tnew - 1'b1;
                end
            end else begin
                r_pc    <= bus.e_pc;
                r_instr <= bus.e_instr;
                r_alu   <= bus.e_alu;
                r_md    <= bus.e_md;
                r_rd2   <= bus.e_rd2;
                r_a2    <= bus.e_a2;
                r_a3    <= bus.e_a3;
                r_we    <= bus.e_we;
                r_wdsel <= bus.e_wdsel;
                r_tnew  <= (bus.e_tnew == '0) ? '0 : bus.e_tnew - 1'b1;
                r_valid <= 1'b1;
            end
        end
    end

    // DM loads have no data yet in M, so that source forwards zero and is never ready.
    always_comb begin
        w_fwdVal = '0;
        case (r_wdsel)
            WDSEL_ALU: w_fwdVal = r_alu;
            WDSEL_MD:  w_fwdVal = r_md;
            WDSEL_PC8: w_fwdVal = r_pc + DW'(8);
            WDSEL_DM:  w_fwdVal = '0;
            default:   w_fwdVal = '0;
        endcase
    end

    assign w_fwdWe    = r_valid & r_we & (r_a3 != '0);
    assign w_fwdReady = w_fwdWe & (r_tnew == '0) & (r_wdsel != WDSEL_DM);

    assign bus.m_pc       = r_pc;
    assign bus.m_instr    = r_instr;
    assign bus.m_alu      = r_alu;
    assign bus.m_md       = r_md;
    assign bus.m_rd2      = r_rd2;
    assign bus.m_a2       = r_a2;
    assign bus.m_a3       = r_a3;
    assign bus.m_we       = r_we;
    assign bus.m_wdsel    = r_wdsel;
    assign bus.m_tnew     = r_tnew;
    assign bus.m_valid    = r_valid;
    assign bus.fwd_val    = w_fwdVal;
    assign bus.fwd_a3     = w_fwdWe ? r_a3 : '0;
    assign bus.fwd_we     = w_fwdWe;
    assign bus.fwd_ready  = w_fwdReady;
    assign bus.bubble_cnt = r_bubbleCnt;

endmodule

// File: tb/tb_em_pipe_reg.sv
// Bench for em_pipe_reg: two instances (KEEP_PC=1/CW=16 and KEEP_PC=0/CW=3) driven identically,
// checked every cycle against a behavioural model, with directed scenarios then random traffic.
module tb_em_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 2;

    typedef struct packed {
        logic        reset;
        logic        stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] rd2;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        we;
        logic [1:0]  wdsel;
        logic [1:0]  tnew;
    } Stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] rd2;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        we;
        logic [1:0]  wdsel;
        logic [1:0]  tnew;
        logic        valid;
    } Model_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] rd2;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic        we;
        logic [1:0]  wdsel;
        logic [1:0]  tnew;
        logic        valid;
        logic [31:0] fwdVal;
        logic [4:0]  fwdA3;
        logic        fwdWe;
        logic        fwdReady;
        logic [31:0] bubble;
    } Obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;

    Model_t m0, m1;
    int     bub0, bub1;
    Obs_t   got0, got1;

    always #5 clk = ~clk;

    em_pipe_reg_if #(.DW(DW), .RW(RW), .TW(TW), .CW(16)) bus0 ();
    em_pipe_reg_if #(.DW(DW), .RW(RW), .TW(TW), .CW(3))  bus1 ();

    em_pipe_reg #(.DW(DW), .RW(RW), .TW(TW), .CW(16), .KEEP_PC(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    em_pipe_reg #(.DW(DW), .RW(RW), .TW(TW), .CW(3), .KEEP_PC(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    assign got0 = {bus0.m_pc, bus0.m_instr, bus0.m_alu, bus0.m_md, bus0.m_rd2, bus0.m_a2, bus0.m_a3,
                   bus0.m_we, bus0.m_wdsel, bus0.m_tnew, bus0.m_valid, bus0.fwd_val, bus0.fwd_a3,
                   bus0.fwd_we, bus0.fwd_ready, 16'd0, bus0.bubble_cnt};
    assign got1 = {bus1.m_pc, bus1.m_instr, bus1.m_alu, bus1.m_md, bus1.m_rd2, bus1.m_a2, bus1.m_a3,
                   bus1.m_we, bus1.m_wdsel, bus1.m_tnew, bus1.m_valid, bus1.fwd_val, bus1.fwd_a3,
                   bus1.fwd_we, bus1.fwd_ready, 29'd0, bus1.bubble_cnt};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Next M-stage contents from the priority rules: reset, flush, stall, capture.
    function automatic Model_t nextModel(input Model_t s, input Stim_t in, input bit keepPc);
        Model_t n;
        n = s;
        if (in.reset) begin
            n = '0;
        end else if (in.flush) begin
            n = '0;
            if (keepPc) n.pc = in.pc;
        end else if (in.stall) begin
            if (s.tnew != 0) n.tnew = s.tnew - 2'd1;
        end else begin
            n.pc    = in.pc;
            n.instr = in.instr;
            n.alu   = in.alu;
            n.md    = in.md;
            n.rd2   = in.rd2;
            n.a2    = in.a2;
            n.a3    = in.a3;
            n.we    = in.we;
            n.wdsel = in.wdsel;
            n.tnew  = (in.tnew == 0) ? 2'd0 : in.tnew - 2'd1;
            n.valid = 1'b1;
        end
        return n;
    endfunction

    function automatic Obs_t expectedObs(input Model_t s, input int bubbles, input int cntMax);
        Obs_t e;
        e.pc       = s.pc;
        e.instr    = s.instr;
        e.alu      = s.alu;
        e.md       = s.md;
        e.rd2      = s.rd2;
        e.a2       = s.a2;
        e.a3       = s.a3;
        e.we       = s.we;
        e.wdsel    = s.wdsel;
        e.tnew     = s.tnew;
        e.valid    = s.valid;
        e.fwdWe    = s.valid && s.we && (s.a3 != 0);
        e.fwdA3    = e.fwdWe ? s.a3 : 5'd0;
        case (s.wdsel)
            2'd1:    e.fwdVal = s.alu;
            2'd3:    e.fwdVal = s.md;
            2'd2:    e.fwdVal = s.pc + 32'd8;
            default: e.fwdVal = 32'd0;
        endcase
        e.fwdReady = e.fwdWe && (s.tnew == 0) && (s.wdsel != 2'd0);
        e.bubble   = (bubbles > cntMax) ? cntMax : bubbles;
        return e;
    endfunction

    task automatic compareDut(input string name, input Obs_t got, input Obs_t exp);
        checkOutput({name, ".m_pc"},       got.pc,       exp.pc);
        checkOutput({name, ".m_instr"},    got.instr,    exp.instr);
        checkOutput({name, ".m_alu"},      got.alu,      exp.alu);
        checkOutput({name, ".m_md"},       got.md,       exp.md);
        checkOutput({name, ".m_rd2"},      got.rd2,      exp.rd2);
        checkOutput({name, ".m_a2"},       got.a2,       exp.a2);
        checkOutput({name, ".m_a3"},       got.a3,       exp.a3);
        checkOutput({name, ".m_we"},       got.we,       exp.we);
        checkOutput({name, ".m_wdsel"},    got.wdsel,    exp.wdsel);
        checkOutput({name, ".m_tnew"},     got.tnew,     exp.tnew);
        checkOutput({name, ".m_valid"},    got.valid,    exp.valid);
        checkOutput({name, ".fwd_val"},    got.fwdVal,   exp.fwdVal);
        checkOutput({name, ".fwd_a3"},     got.fwdA3,    exp.fwdA3);
        checkOutput({name, ".fwd_we"},     got.fwdWe,    exp.fwdWe);
        checkOutput({name, ".fwd_ready"},  got.fwdReady, exp.fwdReady);
        checkOutput({name, ".bubble_cnt"}, got.bubble,   exp.bubble);
    endtask

    // Drive one cycle of inputs to both instances, advance the model, then check both.
    task automatic applyStimulus(input Stim_t s);
        reset         = s.reset;
        bus0.stall    = s.stall;   bus1.stall    = s.stall;
        bus0.flush    = s.flush;   bus1.flush    = s.flush;
        bus0.e_pc     = s.pc;      bus1.e_pc     = s.pc;
        bus0.e_instr  = s.instr;   bus1.e_instr  = s.instr;
        bus0.e_alu    = s.alu;     bus1.e_alu    = s.alu;
        bus0.e_md     = s.md;      bus1.e_md     = s.md;
        bus0.e_rd2    = s.rd2;     bus1.e_rd2    = s.rd2;
        bus0.e_a2     = s.a2;      bus1.e_a2     = s.a2;
        bus0.e_a3     = s.a3;      bus1.e_a3     = s.a3;
        bus0.e_we     = s.we;      bus1.e_we     = s.we;
        bus0.e_wdsel  = s.wdsel;   bus1.e_wdsel  = s.wdsel;
        bus0.e_tnew   = s.tnew;    bus1.e_tnew   = s.tnew;
        @(posedge clk);
        bub0 = s.reset ? 0 : (m0.valid ? bub0 : bub0 + 1);
        bub1 = s.reset ? 0 : (m1.valid ? bub1 : bub1 + 1);
        m0   = nextModel(m0, s, 1'b1);
        m1   = nextModel(m1, s, 1'b0);
        #1;
        compareDut("dut0", got0, expectedObs(m0, bub0, 65535));
        compareDut("dut1", got1, expectedObs(m1, bub1, 7));
    endtask

    function automatic Stim_t randStim();
        Stim_t s;
        s.reset = ($urandom_range(0, 49) == 0);
        s.stall = ($urandom_range(0, 3) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.pc    = $urandom;
        s.instr = $urandom;
        s.alu   = $urandom;
        s.md    = $urandom;
        s.rd2   = $urandom;
        s.a2    = 5'($urandom);
        s.a3    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        s.we    = 1'($urandom);
        s.wdsel = 2'($urandom);
        s.tnew  = 2'($urandom);
        return s;
    endfunction

    initial begin
        Stim_t st;
        m0 = '0; m1 = '0; bub0 = 0; bub1 = 0;
        reset = 1'b1;

        st = '0;
        st.reset = 1'b1;
        repeat (2) applyStimulus(st);
        checkOutput("reset.fwd_we", bus0.fwd_we, 1'b0);

        st = '0;
        st.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(st);
            checkOutput("emptyRamp.bubble_cnt", bus0.bubble_cnt, i + 1);
        end

        st = '0;
        st.pc = 32'h3000; st.alu = 32'h1234; st.a3 = 5'd5; st.we = 1'b1;
        st.wdsel = 2'b01; st.tnew = 2'd1;
        applyStimulus(st);
        checkOutput("capture.fwd_val", bus0.fwd_val, 32'h1234);
        checkOutput("capture.fwd_ready", bus0.fwd_ready, 1'b1);
        checkOutput("capture.fwd_a3", bus0.fwd_a3, 5'd5);

        st = '0;
        st.pc = 32'h3004; st.a3 = 5'd31; st.we = 1'b1; st.wdsel = 2'b10;
        applyStimulus(st);
        checkOutput("pc8.fwd_val", bus0.fwd_val, 32'h300C);
        st.a3 = 5'd0;
        applyStimulus(st);
        checkOutput("a3zero.fwd_we", bus0.fwd_we, 1'b0);
        checkOutput("a3zero.fwd_a3", bus0.fwd_a3, 5'd0);

        st = '0;
        st.pc = 32'h3008; st.alu = 32'hCAFE; st.a3 = 5'd7; st.we = 1'b1;
        st.wdsel = 2'b01; st.tnew = 2'd3;
        applyStimulus(st);
        checkOutput("tnew.capture", bus0.m_tnew, 2'd2);
        checkOutput("tnew.notReady", bus0.fwd_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            st = randStim();
            st.reset = 1'b0; st.flush = 1'b0; st.stall = 1'b1;
            applyStimulus(st);
            checkOutput("stall.m_tnew", bus0.m_tnew, 1 - i);
            checkOutput("stall.m_alu", bus0.m_alu, 32'hCAFE);
        end
        checkOutput("stall.fwd_ready", bus0.fwd_ready, 1'b1);

        st = randStim();
        st.reset = 1'b0; st.flush = 1'b1; st.stall = 1'b1; st.pc = 32'h3010;
        applyStimulus(st);
        checkOutput("flush.m_valid", bus0.m_valid, 1'b0);
        checkOutput("flush.keepPc", bus0.m_pc, 32'h3010);
        checkOutput("flush.clearPc", bus1.m_pc, 32'h0);

        st = '0;
        st.flush = 1'b1;
        repeat (10) applyStimulus(st);
        checkOutput("saturate.bubble_cnt", bus1.bubble_cnt, 3'd7);

        st = '0;
        st.a3 = 5'd4; st.we = 1'b1; st.wdsel = 2'b00; st.tnew = 2'd0;
        applyStimulus(st);
        checkOutput("dm.fwd_we", bus0.fwd_we, 1'b1);
        checkOutput("dm.fwd_ready", bus0.fwd_ready, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(randStim());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
